// File: rtl/rnn_fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rnn_fixed_pkg
//  Description : Shared fixed-point definitions for the RNN layer datapath:
//                word-width derivation, the fixed-point ONE constant,
//                activation type codes, the bias/activation FSM state
//                encoding, a saturation helper and an index-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rnn_fixed_pkg;

    // Default Q-format: 1 sign bit, QN integer bits, QM fractional bits.
    localparam int c_QN_DEFAULT = 6;
    localparam int c_QM_DEFAULT = 11;

    function automatic int fx_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    // Fixed-point representation of 1.0 for a word with qm fractional bits.
    function automatic int fx_one(input int qm);
        return 1 << qm;
    endfunction

    localparam int c_BITWIDTH_DEFAULT = fx_bitwidth(c_QN_DEFAULT, c_QM_DEFAULT);
    localparam int c_ONE_DEFAULT      = fx_one(c_QM_DEFAULT);

    // Activation selector codes.
    localparam int ACT_SIGMOID  = 0;
    localparam int ACT_TANH     = 1;
    localparam int ACT_IDENTITY = 2;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Clamp a signed value into the range of a w-bit two's complement word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Bits needed to index n entries; never less than one.
    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/act_pwl.sv
`default_nettype none
// ============================================================================
//  Module      : act_pwl
//  Description : Combinational piecewise-linear activation on one signed
//                fixed-point word.
//                  ACT_SIGMOID  : y = (x >>> 2) + ONE/2, clamped to [0, ONE]
//                  ACT_TANH     : y = x clamped to [-ONE, ONE]
//                  ACT_IDENTITY : y = x
//  Ports       : i_x  - signed input word  (BITWIDTH bits)
//                o_y  - signed output word (BITWIDTH bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module act_pwl
    import rnn_fixed_pkg::*;
#(
    parameter int BITWIDTH = c_BITWIDTH_DEFAULT,
    parameter int QM       = c_QM_DEFAULT,
    parameter int ACT_TYPE = ACT_SIGMOID
) (
    input  logic signed [BITWIDTH-1:0] i_x,
    output logic signed [BITWIDTH-1:0] o_y
);

    localparam logic signed [BITWIDTH-1:0] c_ONE     = BITWIDTH'(fx_one(QM));
    localparam logic signed [BITWIDTH-1:0] c_NEG_ONE = -c_ONE;
    localparam logic signed [BITWIDTH-1:0] c_HALF    = c_ONE >>> 1;

    generate
        if (ACT_TYPE == ACT_SIGMOID) begin : g_sigmoid
            // x/4 spans at most a quarter of the word range, so adding ONE/2
            // cannot overflow for any format with QM < BITWIDTH-3.
            logic signed [BITWIDTH-1:0] w_t;
            assign w_t = (i_x >>> 2) + c_HALF;
            always_comb begin
                if (w_t[BITWIDTH-1]) begin
                    o_y = '0;
                end else if (w_t > c_ONE) begin
                    o_y = c_ONE;
                end else begin
                    o_y = w_t;
                end
            end
        end else if (ACT_TYPE == ACT_TANH) begin : g_tanh
            always_comb begin
                if (i_x < c_NEG_ONE) begin
                    o_y = c_NEG_ONE;
                end else if (i_x > c_ONE) begin
                    o_y = c_ONE;
                end else begin
                    o_y = i_x;
                end
            end
        end else begin : g_identity
            assign o_y = i_x;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bias_activation.sv
`default_nettype none
// ============================================================================
//  Module      : bias_activation
//  Description : Captures the MAC product vector on the rising edge of its
//                ready flag, adds a per-row bias and applies a shared,
//                two-stage pipelined piecewise-linear activation one row per
//                cycle. The full activated vector is published with a
//                one-cycle actReady pulse.
//  Ports       : clk          - clock
//                reset        - synchronous active-high reset
//                dotVector    - NROW signed products, row i at [i*BITWIDTH +: BITWIDTH]
//                biasVector   - NROW signed biases, same packing
//                dataReadyIn  - MAC ready level
//                actVector    - activated vector, same packing
//                actReady     - one-cycle pulse when actVector updates
//                busy         - a vector is in flight
//                overrun      - one-cycle pulse: a ready edge was dropped
//  Options     : BIAS_SAT_EN - when defined the bias sum saturates to the
//                word range, otherwise it wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module bias_activation
    import rnn_fixed_pkg::*;
#(
    parameter  int NROW     = 16,
    parameter  int QN       = c_QN_DEFAULT,
    parameter  int QM       = c_QM_DEFAULT,
    parameter  int ACT_TYPE = ACT_SIGMOID,
    localparam int BITWIDTH = fx_bitwidth(QN, QM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BITWIDTH*NROW-1:0] dotVector,
    input  logic [BITWIDTH*NROW-1:0] biasVector,
    input  logic                     dataReadyIn,
    output logic [BITWIDTH*NROW-1:0] actVector,
    output logic                     actReady,
    output logic                     busy,
    output logic                     overrun
);

    localparam int              IDXW       = log2_ceil(NROW);
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NROW - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_ready_prev;
    logic                       w_start;
    logic                       w_capture;
    logic                       w_run;
    logic                       w_drain;
    logic                       w_busy;
    logic [IDXW-1:0]            r_idx;

    logic signed [BITWIDTH-1:0] r_dot  [NROW];
    logic signed [BITWIDTH-1:0] r_bias [NROW];
    logic signed [BITWIDTH-1:0] r_work [NROW];

    logic signed [BITWIDTH-1:0] w_dot_sel;
    logic signed [BITWIDTH-1:0] w_bias_sel;
    logic signed [BITWIDTH:0]   w_sum_wide;
    logic signed [BITWIDTH-1:0] w_sum;
    logic signed [BITWIDTH-1:0] w_act;

    logic signed [BITWIDTH-1:0] r_s1_sum;
    logic [IDXW-1:0]            r_s1_idx;
    logic                       r_s1_valid;

    logic [BITWIDTH*NROW-1:0]   w_work_flat;
    logic [BITWIDTH*NROW-1:0]   r_act_vector;
    logic                       r_act_ready;
    logic                       r_overrun;

    // Rising-edge detect; r_ready_prev resets high so a level held across
    // reset release is not mistaken for a new vector.
    assign w_start = dataReadyIn & ~r_ready_prev;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = RUN;
            RUN:     if (r_idx == c_LAST_IDX) w_state_next = DRAIN;
            DRAIN:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_busy    = (r_state != IDLE);
        w_capture = 1'b0;
        w_run     = 1'b0;
        w_drain   = 1'b0;
        case (r_state)
            IDLE:    w_capture = w_start;
            RUN:     w_run     = 1'b1;
            DRAIN:   w_drain   = 1'b1;
            default: w_capture = 1'b0;
        endcase
    end

    // ---------------- Stage 1: bias add ----------------
    assign w_dot_sel  = r_dot[r_idx];
    assign w_bias_sel = r_bias[r_idx];
    assign w_sum_wide = {w_dot_sel[BITWIDTH-1], w_dot_sel} + {w_bias_sel[BITWIDTH-1], w_bias_sel};

`ifdef BIAS_SAT_EN
    assign w_sum = BITWIDTH'(saturate(64'(w_sum_wide), BITWIDTH));
`else
    assign w_sum = BITWIDTH'(w_sum_wide);
`endif

    // ---------------- Activation between the stage registers ----------------
    act_pwl #(
        .BITWIDTH (BITWIDTH),
        .QM       (QM),
        .ACT_TYPE (ACT_TYPE)
    ) u_act_pwl (
        .i_x (r_s1_sum),
        .o_y (w_act)
    );

    // The last row's stage-2 write lands on the same edge that publishes the
    // vector, so the published copy merges it in directly.
    always_comb begin
        for (int r = 0; r < NROW; r++) begin
            if (r_s1_valid && (r_s1_idx == IDXW'(r))) begin
                w_work_flat[r*BITWIDTH +: BITWIDTH] = w_act;
            end else begin
                w_work_flat[r*BITWIDTH +: BITWIDTH] = r_work[r];
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready_prev <= 1'b1;
            r_idx        <= '0;
            r_s1_sum     <= '0;
            r_s1_idx     <= '0;
            r_s1_valid   <= 1'b0;
            r_act_vector <= '0;
            r_act_ready  <= 1'b0;
            r_overrun    <= 1'b0;
            for (int r = 0; r < NROW; r++) begin
                r_dot[r]  <= '0;
                r_bias[r] <= '0;
                r_work[r] <= '0;
            end
        end else begin
            r_ready_prev <= dataReadyIn;
            r_overrun    <= w_start & w_busy;
            r_act_ready  <= w_drain;
            r_s1_valid   <= w_run;

            if (w_capture) begin
                r_idx <= '0;
                for (int r = 0; r < NROW; r++) begin
                    r_dot[r]  <= dotVector[r*BITWIDTH +: BITWIDTH];
                    r_bias[r] <= biasVector[r*BITWIDTH +: BITWIDTH];
                end
            end else if (w_run) begin
                r_idx <= r_idx + IDXW'(1);
            end

            if (w_run) begin
                r_s1_sum <= w_sum;
                r_s1_idx <= r_idx;
            end

            if (r_s1_valid) begin
                r_work[r_s1_idx] <= w_act;
            end

            if (w_drain) begin
                r_act_vector <= w_work_flat;
            end
        end
    end

    assign actVector = r_act_vector;
    assign actReady  = r_act_ready;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_bias_activation.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bias_activation
//  Description : Scoreboard bench for bias_activation. Three instances
//                (sigmoid, tanh, identity) share one stimulus stream; the
//                stimulus process queues the expected vector and publication
//                cycle, a monitor pops and compares on every actReady.
//                Honours BIAS_SAT_EN the same way the design does.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_activation;
    import rnn_fixed_pkg::*;

    localparam int NROW = 16;
    localparam int QN   = 6;
    localparam int QM   = 11;
    localparam int BW   = QN + QM + 1;
    localparam int VW   = BW * NROW;

`ifdef BIAS_SAT_EN
    localparam int c_S7 = 2048, c_T7 = 2048,  c_I7 = 131071;
    localparam int c_S8 = 0,    c_T8 = -2048, c_I8 = -131072;
`else
    localparam int c_S7 = 0,    c_T7 = -2048, c_I7 = -131072;
    localparam int c_S8 = 2048, c_T8 = 2048,  c_I8 = 131071;
`endif

    typedef int row_arr_t [NROW];
    typedef struct {
        logic [VW-1:0] vec;
        int            cyc;
    } exp_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          drdy  = 1'b0;
    logic [VW-1:0] dotv  = '0;
    logic [VW-1:0] biasv = '0;
    logic [VW-1:0] act0, act1, act2;
    logic          rdy0, rdy1, rdy2;
    logic          busy0, busy1, busy2;
    logic          ovr0, ovr1, ovr2;

    int cyc      = 0;
    int checks   = 0;
    int fails    = 0;
    int busy_cnt = 0;
    int rdy_cnt  = 0;
    int ovr_cnt  = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [VW-1:0] last_v [3] = '{default: '0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bias_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(ACT_SIGMOID)) u_sig (
        .clk(clk), .reset(reset), .dotVector(dotv), .biasVector(biasv), .dataReadyIn(drdy),
        .actVector(act0), .actReady(rdy0), .busy(busy0), .overrun(ovr0));
    bias_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(ACT_TANH)) u_tanh (
        .clk(clk), .reset(reset), .dotVector(dotv), .biasVector(biasv), .dataReadyIn(drdy),
        .actVector(act1), .actReady(rdy1), .busy(busy1), .overrun(ovr1));
    bias_activation #(.NROW(NROW), .QN(QN), .QM(QM), .ACT_TYPE(ACT_IDENTITY)) u_id (
        .clk(clk), .reset(reset), .dotVector(dotv), .biasVector(biasv), .dataReadyIn(drdy),
        .actVector(act2), .actReady(rdy2), .busy(busy2), .overrun(ovr2));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int row_of(input logic [VW-1:0] v, input int r);
        logic signed [BW-1:0] t;
        t = v[r*BW +: BW];
        return int'(t);
    endfunction

    function automatic logic [VW-1:0] pack(input row_arr_t v);
        logic [VW-1:0] p;
        p = '0;
        for (int r = 0; r < NROW; r++) p[r*BW +: BW] = BW'(v[r]);
        return p;
    endfunction

    function automatic int ref_sum(input int d, input int b);
        int s;
        logic signed [BW-1:0] t;
        s = d + b;
`ifdef BIAS_SAT_EN
        if (s > 131071)  s = 131071;
        if (s < -131072) s = -131072;
        t = BW'(s);
`else
        t = BW'(s);
`endif
        return int'(t);
    endfunction

    function automatic int ref_act(input int k, input int x);
        int y;
        if (k == 0) begin
            y = (x >>> 2) + 1024;
            if (y < 0)    y = 0;
            if (y > 2048) y = 2048;
        end else if (k == 1) begin
            y = x;
            if (y < -2048) y = -2048;
            if (y > 2048)  y = 2048;
        end else begin
            y = x;
        end
        return y;
    endfunction

    // ---------------- Monitor ----------------
    task automatic mon_inst(input int k, input logic [VW-1:0] v, input logic rdy);
        exp_t e;
        logic have;
        have = 1'b0;
        if (rdy) begin
            if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            if (k == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            if (!have) begin
                chk($sformatf("inst%0d unexpected actReady at cyc %0d", k, cyc), 1, 0);
            end else begin
                chk($sformatf("inst%0d actReady cycle", k), cyc, e.cyc);
                for (int r = 0; r < NROW; r++)
                    chk($sformatf("inst%0d row%0d", k, r), row_of(v, r), row_of(e.vec, r));
            end
            last_v[k] = v;
        end else if (reset) begin
            last_v[k] = v;
        end else begin
            chk($sformatf("inst%0d actVector stable", k), (v === last_v[k]), 1);
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon_inst(0, act0, rdy0);
        mon_inst(1, act1, rdy1);
        mon_inst(2, act2, rdy2);
        if (busy0) busy_cnt++;
        if (rdy0)  rdy_cnt++;
        if (ovr0)  ovr_cnt++;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic apply(input row_arr_t d, input row_arr_t b);
        dotv  = pack(d);
        biasv = pack(b);
    endtask

    task automatic push(input int t_ready, input row_arr_t es, input row_arr_t et,
                        input row_arr_t ei);
        exp_t e;
        e.cyc = t_ready;
        e.vec = pack(es); q0.push_back(e);
        e.vec = pack(et); q1.push_back(e);
        e.vec = pack(ei); q2.push_back(e);
    endtask

    // Raise dataReadyIn for one cycle so it is sampled by posedge number t.
    task automatic pulse_at(input int t);
        while (cyc < t - 1) @(negedge clk);
        drdy = 1'b1;
        @(negedge clk);
        drdy = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        row_arr_t da, ba, sa, ta, ia;
        row_arr_t db, bb, sb, tb2, ib;
        row_arr_t dg, zr;
        int t, b0, r0, o0;

        da = '{0, 4000, 8192, -8192, -3000, 1500, 2049, 131071, -131072, -4, -1, 4092, -4096, 100, 2048, -2047};
        ba = '{0, 96, 0, 0, 0, 0, 0, 1, -1, 0, 0, 0, 0, -300, -4096, 0};
        sa = '{1024, 2048, 2048, 0, 274, 1399, 1536, c_S7, c_S8, 1023, 1023, 2047, 0, 974, 512, 512};
        ta = '{0, 2048, 2048, -2048, -2048, 1500, 2048, c_T7, c_T8, -4, -1, 2048, -2048, -200, -2048, -2047};
        ia = '{0, 4096, 8192, -8192, -3000, 1500, 2049, c_I7, c_I8, -4, -1, 4092, -4096, -200, -2048, -2047};
        for (int r = 0; r < NROW; r++) begin
            db[r]  = r * 700 - 5000;
            bb[r]  = 123 - 20 * r;
            sb[r]  = ref_act(0, ref_sum(db[r], bb[r]));
            tb2[r] = ref_act(1, ref_sum(db[r], bb[r]));
            ib[r]  = ref_act(2, ref_sum(db[r], bb[r]));
            dg[r]  = 9000 + r;
            zr[r]  = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset actVector zero inst0", (act0 === '0), 1);
        chk("reset actVector zero inst2", (act2 === '0), 1);
        chk("reset actReady", rdy0, 0);
        chk("reset busy", busy0, 0);
        chk("reset overrun", ovr0, 0);
        reset = 1'b0;
        @(negedge clk);

        // Ready held high for two cycles: exactly one capture
        apply(da, ba);
        b0 = busy_cnt; r0 = rdy_cnt; o0 = ovr_cnt;
        t = cyc + 1;
        push(t + 17, sa, ta, ia);
        drdy = 1'b1;
        repeat (2) @(negedge clk);
        drdy = 1'b0;
        wait_to(t + 24);
        chk("long ready: busy cycles", busy_cnt - b0, 17);
        chk("long ready: actReady count", rdy_cnt - r0, 1);
        chk("long ready: overrun count", ovr_cnt - o0, 0);

        // Edge while running is dropped; edge in the publishing cycle is taken
        b0 = busy_cnt; r0 = rdy_cnt; o0 = ovr_cnt;
        t = cyc + 2;
        push(t + 17, sa, ta, ia);
        pulse_at(t);
        apply(dg, zr);
        pulse_at(t + 5);
        apply(db, bb);
        push(t + 35, sb, tb2, ib);
        pulse_at(t + 18);
        wait_to(t + 42);
        chk("mid-run edge: overrun count", ovr_cnt - o0, 1);
        chk("back-to-back: actReady count", rdy_cnt - r0, 2);
        chk("back-to-back: busy cycles", busy_cnt - b0, 34);

        // Edge during DRAIN is dropped
        b0 = busy_cnt; r0 = rdy_cnt; o0 = ovr_cnt;
        t = cyc + 2;
        apply(da, ba);
        push(t + 17, sa, ta, ia);
        pulse_at(t);
        apply(dg, zr);
        pulse_at(t + 17);
        wait_to(t + 40);
        chk("drain edge: overrun count", ovr_cnt - o0, 1);
        chk("drain edge: actReady count", rdy_cnt - r0, 1);

        // Reset mid-operation aborts the vector
        apply(db, bb);
        b0 = busy_cnt; r0 = rdy_cnt;
        t = cyc + 2;
        pulse_at(t);
        wait_to(t + 7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort: busy after reset", busy0, 0);
        chk("abort: actVector zero inst0", (act0 === '0), 1);
        chk("abort: actVector zero inst1", (act1 === '0), 1);
        chk("abort: actReady", rdy0, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_to(t + 30);
        chk("abort: actReady count", rdy_cnt - r0, 0);
        chk("abort: busy cycles", busy_cnt - b0, 8);

        // Ready rising with reset, held through release: no capture
        apply(da, ba);
        b0 = busy_cnt; r0 = rdy_cnt;
        drdy  = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("held ready: busy cycles", busy_cnt - b0, 0);
        chk("held ready: actReady count", rdy_cnt - r0, 0);
        drdy = 1'b0;
        @(negedge clk);
        t = cyc + 1;
        push(t + 17, sa, ta, ia);
        drdy = 1'b1;
        @(negedge clk);
        drdy = 1'b0;
        wait_to(t + 22);
        chk("fresh edge after reset: actReady count", rdy_cnt - r0, 1);

        chk("scoreboard drained inst0", q0.size(), 0);
        chk("scoreboard drained inst1", q1.size(), 0);
        chk("scoreboard drained inst2", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bias_activation.md
# bias_activation

Downstream stage of the dot-product MAC in each RNN layer. Captures the NROW-wide product vector on the rising edge of the MAC's ready flag and adds a per-row bias. Applies a piecewise-linear activation through a single shared, two-stage pipelined datapath, one row per cycle, and presents the activated vector with a one-cycle ready pulse to the gate/state-update logic.

## Interface
- NROW, 16, rows per vector
- QN, 6, integer bits
- QM, 11, fractional bits; BITWIDTH = QN+QM+1
- ACT_TYPE, 0, 0 = hard sigmoid, 1 = hard tanh, 2 = identity
- clk  in  1  clock; one clock
- reset  in  1  synchronous, active-high reset
- dotVector  in  BITWIDTH*NROW  signed products, row i at [i*BITWIDTH +: BITWIDTH]
- biasVector  in  BITWIDTH*NROW  signed biases, same packing
- dataReadyIn  in  1  MAC ready level; may stay high several cycles
- actVector  out  BITWIDTH*NROW  activated vector, same packing
- actReady  out  1  one-cycle pulse: actVector updated
- busy  out  1  high while a vector is in flight
- overrun  out  1  one-cycle pulse: ready edge dropped while busy

## Operation
- Edge detect: `start = dataReadyIn & ~readyPrev`; readyPrev is a register.
- Start handling in IDLE: on start, latch dotVector and biasVector, set idx = 0, go to RUN.
- Start handling in RUN or DRAIN: start pulses overrun. Latched data is untouched.
- FSM: IDLE -> RUN on start; RUN -> RUN while idx < NROW-1; RUN -> DRAIN at idx == NROW-1; DRAIN -> IDLE.
- Stage 1 (RUN): `sum = dot[idx] + bias[idx]`, computed at BITWIDTH+1 bits and reduced to BITWIDTH (see Configuration), then registered with its idx.
- Stage 2 (cycle after stage 1): the activation of the stage-1 register is written into work row idx.
- Activation, with ONE = 2^QM:
  - sigmoid: `y = (x >>> 2) + (ONE >>> 1)`, clamped to [0, ONE]
  - tanh: x clamped to [-ONE, ONE]
  - identity: `y = x`
- Leaving DRAIN: the full work register is copied to actVector and actReady is set. actVector changes only at this point, so it is stable between pulses.
- busy = (state != IDLE).
- Reset values:
  - actVector, actReady, busy, overrun: 0
  - state: IDLE
  - idx: 0
  - readyPrev: 1, so a level held high across reset release is not a start.
- Reset mid-operation aborts the vector; no actReady is produced for it.

## Timing
- Cycle E: first cycle dataReadyIn is sampled high after low.
- RUN: cycles E+1 .. E+NROW. DRAIN: cycle E+NROW+1.
- actReady high and actVector valid in cycle E+NROW+2; latency NROW+2.
- busy high in cycles E+1 .. E+NROW+1.
- A start in cycle E+NROW+2 (state IDLE) is accepted. Throughput is one vector per NROW+2 cycles.
- Start in the same cycle as the DRAIN -> IDLE transition is dropped, and overrun pulses.
- Start and reset in the same cycle: reset wins, nothing is captured.

## Configuration
- BIAS_SAT_EN defined: the bias sum saturates to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
- BIAS_SAT_EN undefined: the sum wraps (low BITWIDTH bits kept). No other behaviour changes.

## Structure
- Package rnn_fixed_pkg:
  - BITWIDTH derivation and fixed-point ONE constant
  - ACT_SIGMOID / ACT_TANH / ACT_IDENTITY codes
  - FSM state enum (IDLE, RUN, DRAIN)
  - saturate function
  - log2 function for the idx width
- Sub-module act_pwl: combinational activation on one BITWIDTH word, parameterised by QM and ACT_TYPE. It sits between the stage-1 and stage-2 registers.

## Test plan
Defaults apply (QN=6, QM=11, ONE = 2048, NROW = 16).
- Sigmoid: row 0 dot = 0, bias = 0 -> 1024. Row 1 dot = 4000, bias = 96 -> 2048. Row 2 dot = 8192 -> 2048. Row 3 dot = -8192 -> 0. actReady exactly at E+18, busy high for 17 cycles.
- Tanh (ACT_TYPE=1): row 0 = -3000 -> -2048; row 1 = 1500 -> 1500; row 2 = 2049 -> 2048.
- Identity with dot = 131071, bias = 1: BIAS_SAT_EN -> 131071; without the macro -> -131072.
- dataReadyIn held high 2 cycles -> exactly one capture. A second rising edge at E+5 -> overrun pulse, and the result equals the first vector's. An edge at E+18 -> accepted, second actReady at E+36.
- Reset asserted at E+8 -> no actReady, actVector = 0, busy = 0 next cycle. dataReadyIn held high through reset release -> no capture until it goes low then high.
